// File: rtl/reg_file_sb.sv
// Integer register file with two prioritised write ports, bypassed combinational reads
// and an integrated busy-bit scoreboard for RAW hazard detection at decode.
module reg_file_sb #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] rs1_out,
   output logic [XLEN-1:0] rs2_out,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            wa_we,
   input  logic [AW-1:0]   wa_rd,
   input  logic [XLEN-1:0] wa_data,
   input  logic            wb_we,
   input  logic [AW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_rd,
   output logic [AW:0]     busy_cnt,
   output logic            busy_any
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic [AW:0]      busy_cnt_q;
   logic [AW:0]      busy_cnt_d;
   logic             busy_any_q;

   logic [NREGS-1:0] wa_sel_s;
   logic [NREGS-1:0] wb_sel_s;
   logic [NREGS-1:0] iss_sel_s;
   logic [NREGS-1:0] wr_hit_s;

   function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
      logic [AW:0] cnt;
      cnt = {(AW+1){1'b0}};
      for (int i = 0; i < NREGS; i++) begin
         cnt = cnt + {{AW{1'b0}}, v[i]};
      end
      return cnt;
   endfunction

   // One-hot decode of write and issue targets; register 0 and reset cycles never select.
   always_comb begin
      wa_sel_s  = {NREGS{1'b0}};
      wb_sel_s  = {NREGS{1'b0}};
      iss_sel_s = {NREGS{1'b0}};
      for (int r = 1; r < NREGS; r++) begin
         wa_sel_s[r]  = rst_n & wa_we     & (wa_rd  == AW'(r));
         wb_sel_s[r]  = rst_n & wb_we     & (wb_rd  == AW'(r));
         iss_sel_s[r] = rst_n & iss_valid & (iss_rd == AW'(r));
      end
      wr_hit_s = wa_sel_s | wb_sel_s;
   end

   // Next-state storage and busy bits; issue set beats a same-cycle writeback clear.
   always_comb begin
      regs_d[0] = {XLEN{1'b0}};
      busy_d    = {NREGS{1'b0}};
      for (int r = 1; r < NREGS; r++) begin
         if (wa_sel_s[r]) begin
            regs_d[r] = wa_data;
         end else if (wb_sel_s[r]) begin
            regs_d[r] = wb_data;
         end else begin
            regs_d[r] = regs_q[r];
         end
         if (iss_sel_s[r]) begin
            busy_d[r] = 1'b1;
         end else if (wr_hit_s[r]) begin
            busy_d[r] = 1'b0;
         end else begin
            busy_d[r] = busy_q[r];
         end
      end
      busy_cnt_d = popcount(busy_d);
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) begin
            regs_q[r] <= {XLEN{1'b0}};
         end
         busy_q     <= {NREGS{1'b0}};
         busy_cnt_q <= {(AW+1){1'b0}};
         busy_any_q <= 1'b0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            regs_q[r] <= regs_d[r];
         end
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
         busy_any_q <= (busy_cnt_d != {(AW+1){1'b0}});
      end
   end

   // Read ports: a write landing this cycle is forwarded (A over B) and satisfies busy.
   always_comb begin
      if (wr_hit_s[rs1]) begin
         rs1_out = wa_sel_s[rs1] ? wa_data : wb_data;
      end else begin
         rs1_out = regs_q[rs1];
      end
      if (wr_hit_s[rs2]) begin
         rs2_out = wa_sel_s[rs2] ? wa_data : wb_data;
      end else begin
         rs2_out = regs_q[rs2];
      end
      rs1_busy = busy_q[rs1] & ~wr_hit_s[rs1];
      rs2_busy = busy_q[rs2] & ~wr_hit_s[rs2];
   end

   assign busy_cnt = busy_cnt_q;
   assign busy_any = busy_any_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb: inputs change on the falling edge,
// combinational outputs are checked 1ns later, registered outputs one cycle on.
module tb_reg_file_sb;
   localparam int XLEN = 32;
   localparam int NREGS = 32;
   localparam int AW = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [AW-1:0]   rs1, rs2;
   logic [XLEN-1:0] rs1_out, rs2_out;
   logic            rs1_busy, rs2_busy;
   logic            wa_we, wb_we, iss_valid;
   logic [AW-1:0]   wa_rd, wb_rd, iss_rd;
   logic [XLEN-1:0] wa_data, wb_data;
   logic [AW:0]     busy_cnt;
   logic            busy_any;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
      .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2),
      .rs1_out(rs1_out), .rs2_out(rs2_out), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .wa_we(wa_we), .wa_rd(wa_rd), .wa_data(wa_data),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .iss_valid(iss_valid), .iss_rd(iss_rd),
      .busy_cnt(busy_cnt), .busy_any(busy_any)
   );

   task automatic idle_inputs();
      wa_we = 1'b0; wa_rd = '0; wa_data = '0;
      wb_we = 1'b0; wb_rd = '0; wb_data = '0;
      iss_valid = 1'b0; iss_rd = '0;
   endtask

   task automatic test_reset();
      @(negedge clk); rst_n = 1'b0; idle_inputs(); rs1 = '0; rs2 = '0;
      @(negedge clk);
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < NREGS; i++) begin
         rs1 = AW'(i); rs2 = AW'(NREGS - 1 - i); #1;
         n_checks++; if (rs1_out !== 32'h0) begin n_fail++; $display("FAIL reset_rs1_out r%0d: got %h want 0", i, rs1_out); end
         n_checks++; if (rs2_out !== 32'h0) begin n_fail++; $display("FAIL reset_rs2_out r%0d: got %h want 0", i, rs2_out); end
         n_checks++; if ({rs1_busy, rs2_busy} !== 2'b00) begin n_fail++; $display("FAIL reset_busy r%0d: got %b want 00", i, {rs1_busy, rs2_busy}); end
      end
      n_checks++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_busy_cnt: got %0d want 0", busy_cnt); end
      n_checks++; if (busy_any !== 1'b0) begin n_fail++; $display("FAIL reset_busy_any: got %b want 0", busy_any); end
      // Write and issue to r0 are both dropped.
      @(negedge clk); wa_we = 1'b1; wa_rd = 5'd0; wa_data = 32'hDEADBEEF; iss_valid = 1'b1; iss_rd = 5'd0; rs1 = 5'd0; #1;
      n_checks++; if (rs1_out !== 32'h0) begin n_fail++; $display("FAIL r0_bypass: got %h want 0", rs1_out); end
      @(negedge clk); idle_inputs(); #1;
      n_checks++; if (rs1_out !== 32'h0) begin n_fail++; $display("FAIL r0_stored: got %h want 0", rs1_out); end
      n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL r0_busy: got %b want 0", rs1_busy); end
      n_checks++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL r0_busy_cnt: got %0d want 0", busy_cnt); end
   endtask

   task automatic test_bypass();
      @(negedge clk); wa_we = 1'b1; wa_rd = 5'd5; wa_data = 32'h12345678; rs1 = 5'd5; #1;
      n_checks++; if (rs1_out !== 32'h12345678) begin n_fail++; $display("FAIL bypass_a: got %h want 12345678", rs1_out); end
      @(negedge clk); idle_inputs(); #1;
      n_checks++; if (rs1_out !== 32'h12345678) begin n_fail++; $display("FAIL stored_a: got %h want 12345678", rs1_out); end
      // Port B alone to a distinct register, bypassed on rs2.
      @(negedge clk); wb_we = 1'b1; wb_rd = 5'd6; wb_data = 32'h0BADF00D; rs2 = 5'd6; #1;
      n_checks++; if (rs2_out !== 32'h0BADF00D) begin n_fail++; $display("FAIL bypass_b: got %h want 0badf00d", rs2_out); end
      @(negedge clk); idle_inputs(); #1;
      n_checks++; if (rs2_out !== 32'h0BADF00D) begin n_fail++; $display("FAIL stored_b: got %h want 0badf00d", rs2_out); end
   endtask

   task automatic test_dual_write();
      @(negedge clk); wa_we = 1'b1; wa_rd = 5'd7; wa_data = 32'hAAAA0000;
      wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h5555FFFF; rs2 = 5'd7; #1;
      n_checks++; if (rs2_out !== 32'hAAAA0000) begin n_fail++; $display("FAIL dual_bypass: got %h want aaaa0000", rs2_out); end
      @(negedge clk); idle_inputs(); #1;
      n_checks++; if (rs2_out !== 32'hAAAA0000) begin n_fail++; $display("FAIL dual_stored: got %h want aaaa0000", rs2_out); end
   endtask

   task automatic test_scoreboard();
      @(negedge clk); iss_valid = 1'b1; iss_rd = 5'd3; rs1 = 5'd3; #1;
      n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL issue_same_cycle_busy: got %b want 0", rs1_busy); end
      @(negedge clk); idle_inputs(); #1;
      n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL sb_busy: got %b want 1", rs1_busy); end
      n_checks++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL sb_cnt_1: got %0d want 1", busy_cnt); end
      n_checks++; if (busy_any !== 1'b1) begin n_fail++; $display("FAIL sb_any_1: got %b want 1", busy_any); end
      @(negedge clk); wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h42; #1;
      n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL sb_wb_busy: got %b want 0", rs1_busy); end
      n_checks++; if (rs1_out !== 32'h42) begin n_fail++; $display("FAIL sb_wb_data: got %h want 42", rs1_out); end
      @(negedge clk); idle_inputs(); #1;
      n_checks++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL sb_cnt_0: got %0d want 0", busy_cnt); end
      n_checks++; if (busy_any !== 1'b0) begin n_fail++; $display("FAIL sb_any_0: got %b want 0", busy_any); end
   endtask

   task automatic test_issue_write_same();
      @(negedge clk); iss_valid = 1'b1; iss_rd = 5'd9; rs1 = 5'd9;
      @(negedge clk); iss_valid = 1'b1; iss_rd = 5'd9; wa_we = 1'b1; wa_rd = 5'd9; wa_data = 32'h99; #1;
      n_checks++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL iw_cnt_before: got %0d want 1", busy_cnt); end
      @(negedge clk); idle_inputs(); #1;
      n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL iw_busy: got %b want 1", rs1_busy); end
      n_checks++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL iw_cnt_after: got %0d want 1", busy_cnt); end
      n_checks++; if (rs1_out !== 32'h99) begin n_fail++; $display("FAIL iw_data: got %h want 99", rs1_out); end
      @(negedge clk); wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'h99;
      @(negedge clk); idle_inputs(); #1;
      n_checks++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL iw_cleanup_cnt: got %0d want 0", busy_cnt); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk); iss_valid = 1'b1; iss_rd = 5'd1;
      @(negedge clk); iss_rd = 5'd2;
      @(negedge clk); iss_rd = 5'd3;
      @(negedge clk); idle_inputs(); wa_we = 1'b1; wa_rd = 5'd1; wa_data = 32'h11;
      wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'h22; #1;
      n_checks++; if (busy_cnt !== 6'd3) begin n_fail++; $display("FAIL b2b_cnt_3: got %0d want 3", busy_cnt); end
      @(negedge clk); idle_inputs(); rs1 = 5'd3; rs2 = 5'd2; #1;
      n_checks++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL b2b_cnt_1: got %0d want 1", busy_cnt); end
      n_checks++; if ({rs1_busy, rs2_busy} !== 2'b10) begin n_fail++; $display("FAIL b2b_busy: got %b want 10", {rs1_busy, rs2_busy}); end
      n_checks++; if (rs2_out !== 32'h22) begin n_fail++; $display("FAIL b2b_r2: got %h want 22", rs2_out); end
      // Reset alongside an issue and a write: both ignored, bypass off.
      @(negedge clk); rst_n = 1'b0; iss_valid = 1'b1; iss_rd = 5'd5;
      wa_we = 1'b1; wa_rd = 5'd5; wa_data = 32'hFFFFFFFF; rs1 = 5'd5; #1;
      n_checks++; if (rs1_out !== 32'h12345678) begin n_fail++; $display("FAIL rst_no_bypass: got %h want 12345678", rs1_out); end
      @(negedge clk); rst_n = 1'b1; idle_inputs(); rs2 = 5'd3; #1;
      n_checks++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", busy_cnt); end
      n_checks++; if (busy_any !== 1'b0) begin n_fail++; $display("FAIL rst_any: got %b want 0", busy_any); end
      n_checks++; if ({rs1_busy, rs2_busy} !== 2'b00) begin n_fail++; $display("FAIL rst_busy: got %b want 00", {rs1_busy, rs2_busy}); end
      n_checks++; if (rs1_out !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", rs1_out); end
   endtask

   initial begin
      rst_n = 1'b0;
      rs1 = '0; rs2 = '0;
      idle_inputs();
      test_reset();
      test_bypass();
      test_dual_write();
      test_scoreboard();
      test_issue_write_same();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
